gauss3x3_filter: RTL and testbench

//  3x3 Gaussian smoothing stage fed by maxtri3x3_shift (three row-aligned AXI-Stream lines).

---
 rtl/img_pkg.sv | 23 ++
 rtl/gauss3x3_core.sv | 26 ++
 rtl/gauss3x3_filter.sv | 156 +++++++++++++++
 tb/tb_gauss3x3_filter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: window FSM states, 1-2-1 kernel constants
// and the vertical column-sum helper.
package img_pkg;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int KERNEL_SHIFT = 4;
    localparam int ROUND_OFFSET = 8;

    // Widest pixel the helper supports; callers size-cast in and out.
    localparam int MAX_DW = 16;

    function automatic logic [MAX_DW+1:0] vsum(input logic [MAX_DW-1:0] top,
                                               input logic [MAX_DW-1:0] mid,
                                               input logic [MAX_DW-1:0] bot);
        return (MAX_DW+2)'(top) + ((MAX_DW+2)'(mid) << 1) + (MAX_DW+2)'(bot);
    endfunction

endpackage

// File: rtl/gauss3x3_core.sv
// Combinational horizontal 1-2-1 pass over three vertical column sums, with
// rounding and normalisation by 16.
module gauss3x3_core
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH+1:0] col_l,
    input  logic [DATA_WIDTH+1:0] col_c,
    input  logic [DATA_WIDTH+1:0] col_r,
    output logic [DATA_WIDTH-1:0] pix
);

    localparam int SW = DATA_WIDTH + 4;

    logic [SW-1:0] sum;
    logic [SW-1:0] rounded;

    // Peak sum plus offset stays below 2^SW, so no saturation is required.
    always_comb begin
        sum     = SW'(col_l) + (SW'(col_c) << 1) + SW'(col_r);
        rounded = sum + SW'(ROUND_OFFSET);
        pix     = DATA_WIDTH'(rounded >> KERNEL_SHIFT);
    end

endmodule

// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian smoothing over three row-aligned AXI-Stream lines, with
// horizontal edge replication and a sticky line-length error flag.
module gauss3x3_filter
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 2560,
    parameter int IMG_HEIGHT = 1440
) (
    input  logic                  s_axis_aclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_0_tdata,
    input  logic                  s_axis_line_buff_0_tvalid,
    input  logic                  s_axis_line_buff_0_tuser,
    input  logic                  s_axis_line_buff_0_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_1_tdata,
    input  logic                  s_axis_line_buff_1_tvalid,
    input  logic                  s_axis_line_buff_1_tuser,
    input  logic                  s_axis_line_buff_1_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_2_tdata,
    input  logic                  s_axis_line_buff_2_tvalid,
    input  logic                  s_axis_line_buff_2_tuser,
    input  logic                  s_axis_line_buff_2_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err_line_len
);

    localparam int VW = DATA_WIDTH + 2;
    localparam int CW = $clog2(IMG_WIDTH + 1) + 1;
    localparam logic [CW:0] LINE_LEN = (CW+1)'(IMG_WIDTH);

    state_t state, state_nxt;

    logic [VW-1:0]         win_l, win_c, win_r, v_in;
    logic [DATA_WIDTH-1:0] pix;
    logic [CW-1:0]         col_cnt;
    logic [CW:0]           cur_len;
    logic                  all_valid, advance, accept, produce, out_last;
    logic                  restart, restart_go, line_user;
    logic                  unused_ok;

    assign unused_ok = ^{s_axis_line_buff_0_tuser, s_axis_line_buff_0_tlast,
                         s_axis_line_buff_2_tuser, s_axis_line_buff_2_tlast,
                         (IMG_HEIGHT > 0)};

    assign all_valid = s_axis_line_buff_0_tvalid & s_axis_line_buff_1_tvalid &
                       s_axis_line_buff_2_tvalid;
    assign advance   = ~m_axis_tvalid | m_axis_tready;

    assign v_in = VW'(vsum(MAX_DW'(s_axis_line_buff_0_tdata),
                           MAX_DW'(s_axis_line_buff_1_tdata),
                           MAX_DW'(s_axis_line_buff_2_tdata)));

    // Length the line would have if the current beat were its last one.
    assign cur_len = (state == FIRST) ? (CW+1)'(1) : {1'b0, col_cnt} + (CW+1)'(1);

    always_ff @(posedge s_axis_aclk) begin
        if (!resetn) state <= FIRST;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        accept        = 1'b0;
        produce       = 1'b0;
        out_last      = 1'b0;
        restart       = 1'b0;
        restart_go    = 1'b0;
        win_r         = win_c;
        case (state)
            FIRST: begin
                s_axis_tready = resetn & advance;
                accept        = s_axis_tready & all_valid;
                if (accept)
                    state_nxt = s_axis_line_buff_1_tlast ? FLUSH : RUN;
            end
            RUN: begin
                // A new-frame beat is left pending until this line is flushed.
                restart       = all_valid & s_axis_line_buff_1_tuser;
                s_axis_tready = resetn & advance & ~restart;
                accept        = s_axis_tready & all_valid;
                restart_go    = restart & advance;
                win_r         = v_in;
                produce       = accept;
                if ((accept & s_axis_line_buff_1_tlast) | restart_go)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                produce  = advance;
                out_last = 1'b1;
                if (advance)
                    state_nxt = FIRST;
            end
            default: state_nxt = FIRST;
        endcase
    end

    gauss3x3_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .col_l(win_l),
        .col_c(win_c),
        .col_r(win_r),
        .pix  (pix)
    );

    always_ff @(posedge s_axis_aclk) begin
        if (!resetn) begin
            win_l         <= '0;
            win_c         <= '0;
            col_cnt       <= '0;
            line_user     <= 1'b0;
            err_line_len  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (state == FIRST) begin
                col_cnt <= accept ? CW'(1) : '0;
                if (accept) begin
                    win_l     <= v_in;
                    win_c     <= v_in;
                    line_user <= s_axis_line_buff_1_tuser;
                end
            end else if (accept) begin
                win_l <= win_c;
                win_c <= v_in;
                if (col_cnt != '1)
                    col_cnt <= col_cnt + CW'(1);
            end

            if (accept && s_axis_line_buff_1_tlast && (cur_len != LINE_LEN))
                err_line_len <= 1'b1;
            if (restart_go && ({1'b0, col_cnt} != LINE_LEN))
                err_line_len <= 1'b1;

            if (advance) begin
                m_axis_tvalid <= produce;
                m_axis_tuser  <= produce & line_user;
                m_axis_tlast  <= produce & out_last;
                if (produce) begin
                    m_axis_tdata <= pix;
                    line_user    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gauss3x3_filter.sv
// Self-checking bench for gauss3x3_filter: directed vector table, a reset and
// frame-restart sequence, and randomized lines checked against a clamped-index model.
module tb_gauss3x3_filter;

    localparam int DW = 8;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0;
    logic          v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic          u0 = 1'b0, u1 = 1'b0, u2 = 1'b0;
    logic          l0 = 1'b0, l1 = 1'b0, l2 = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tuser, m_tlast;
    logic          m_tready = 1'b1;
    logic          err;

    gauss3x3_filter #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(4)
    ) dut (
        .s_axis_aclk              (clk),
        .resetn                   (resetn),
        .s_axis_line_buff_0_tdata (d0),
        .s_axis_line_buff_0_tvalid(v0),
        .s_axis_line_buff_0_tuser (u0),
        .s_axis_line_buff_0_tlast (l0),
        .s_axis_line_buff_1_tdata (d1),
        .s_axis_line_buff_1_tvalid(v1),
        .s_axis_line_buff_1_tuser (u1),
        .s_axis_line_buff_1_tlast (l1),
        .s_axis_line_buff_2_tdata (d2),
        .s_axis_line_buff_2_tvalid(v2),
        .s_axis_line_buff_2_tuser (u2),
        .s_axis_line_buff_2_tlast (l2),
        .s_axis_tready            (s_tready),
        .m_axis_tdata             (m_tdata),
        .m_axis_tvalid            (m_tvalid),
        .m_axis_tuser             (m_tuser),
        .m_axis_tlast             (m_tlast),
        .m_axis_tready            (m_tready),
        .err_line_len             (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]         len;
        logic               user;
        logic [7:0][DW-1:0] top;
        logic [7:0][DW-1:0] mid;
        logic [7:0][DW-1:0] bot;
        logic [7:0][DW-1:0] exp;
        logic               exp_err;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    logic [DW+1:0] exp_q [$];   // {data, tuser, tlast}
    int unsigned   n_checks = 0;
    int unsigned   n_pass = 0;
    bit            chk_en = 1'b0;
    int unsigned   rmode = 0;   // 0: always ready, 1: toggle, 2: random

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output scoreboard and stall check, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en && resetn) begin
            if (m_tvalid && !m_tready)
                check_eq("tready_when_stalled", {31'b0, s_tready}, 32'd0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0)
                    check_eq("extra_output", exp_q.size(), 32'd1);
                else
                    check_eq("out_pixel", {22'b0, m_tdata, m_tuser, m_tlast},
                             {22'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_rows(input logic [2:0] vld, input logic [DW-1:0] a, b, c,
                              input logic user, input logic last);
        {v0, v1, v2} = {vld[0], vld[1], vld[2]};
        d0 = a; d1 = b; d2 = c;
        u1 = user; l1 = last;
        u0 = 1'($urandom_range(0, 1)); l0 = 1'($urandom_range(0, 1));
        u2 = 1'($urandom_range(0, 1)); l2 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_accept();
        int unsigned c = 0;
        logic acc = 1'b0;
        while (!acc && c < 1000) begin
            @(negedge clk);
            acc = s_tready;
            c++;
        end
        check_eq("beat_accept", {31'b0, acc}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int unsigned len, input bit user,
                             input logic [7:0][DW-1:0] t, m, b,
                             input bit with_last, input bit glitch);
        for (int unsigned i = 0; i < len; i++) begin
            if (glitch && $urandom_range(0, 3) == 0) begin
                drive_rows(3'($urandom_range(1, 6)), 8'($urandom), 8'($urandom),
                           8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                @(posedge clk);
                #1;
            end
            drive_rows(3'b111, t[i], m[i], b[i], user && (i == 0),
                       with_last && (i == len - 1));
            wait_accept();
        end
        drive_rows(3'b000, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Reference: column sums with clamped indices, then rounded 1-2-1 / 16.
    task automatic model_line(input int unsigned len, input bit user,
                              input logic [7:0][DW-1:0] t, m, b);
        int unsigned v [8];
        int unsigned lft, rgt, o;
        for (int unsigned i = 0; i < len; i++)
            v[i] = int'(t[i]) + 2 * int'(m[i]) + int'(b[i]);
        for (int unsigned x = 0; x < len; x++) begin
            lft = (x == 0) ? v[0] : v[x-1];
            rgt = (x == len - 1) ? v[x] : v[x+1];
            o   = (lft + 2 * v[x] + rgt + 8) / 16;
            exp_q.push_back({8'(o), user && (x == 0), x == len - 1});
        end
    endtask

    task automatic drain();
        int unsigned c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        check_eq("drain_outputs", exp_q.size(), 32'd0);
    endtask

    task automatic run_table(input bit pass);
        for (int k = 0; k < NV; k++) begin
            for (int unsigned x = 0; x < 32'(vecs[k].len); x++)
                exp_q.push_back({vecs[k].exp[x], vecs[k].user && (x == 0),
                                 x == 32'(vecs[k].len) - 1});
            send_line(vecs[k].len, vecs[k].user, vecs[k].top, vecs[k].mid,
                      vecs[k].bot, 1'b1, 1'b0);
            drain();
            check_eq($sformatf("err_after_vec%0d", k), {31'b0, err},
                     {31'b0, pass ? 1'b1 : vecs[k].exp_err});
        end
    endtask

    initial begin
        logic [7:0][DW-1:0] rt, rm, rb;

        vecs[0] = '0;
        vecs[0].len = 4'd8; vecs[0].user = 1'b1;
        vecs[0].top = {8{8'd100}}; vecs[0].mid = {8{8'd100}};
        vecs[0].bot = {8{8'd100}}; vecs[0].exp = {8{8'd100}};
        vecs[1] = '0;
        vecs[1].len = 4'd8;
        vecs[1].mid[3] = 8'd255;
        vecs[1].exp[2] = 8'd32; vecs[1].exp[3] = 8'd64; vecs[1].exp[4] = 8'd32;
        vecs[2] = '0;
        vecs[2].len = 4'd8;
        for (int i = 0; i < 8; i++) begin
            vecs[2].top[i] = 8'(16 * i);
            vecs[2].mid[i] = 8'(16 * i);
            vecs[2].bot[i] = 8'(16 * i);
        end
        vecs[2].exp = {8'd108, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16, 8'd4};
        vecs[3] = '0;
        vecs[3].len = 4'd5; vecs[3].exp_err = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vecs[3].top[i] = 8'd50; vecs[3].mid[i] = 8'd50;
            vecs[3].bot[i] = 8'd50; vecs[3].exp[i] = 8'd50;
        end
        vecs[4] = '0;
        vecs[4].len = 4'd1; vecs[4].exp_err = 1'b1;
        vecs[4].top[0] = 8'd77; vecs[4].mid[0] = 8'd77;
        vecs[4].bot[0] = 8'd77; vecs[4].exp[0] = 8'd77;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        check_eq("rst_tdata", {24'b0, m_tdata}, 32'd0);
        check_eq("rst_tuser", {31'b0, m_tuser}, 32'd0);
        check_eq("rst_tlast", {31'b0, m_tlast}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_s_tready", {31'b0, s_tready}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_s_tready", {31'b0, s_tready}, 32'd1);
        chk_en = 1'b1;

        // Directed table, downstream always ready.
        rmode = 0;
        run_table(1'b0);

        // Reset mid-line discards the partial line and clears the error.
        chk_en = 1'b0;
        send_line(4, 1'b1, vecs[0].top, vecs[0].mid, vecs[0].bot, 1'b0, 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_tvalid", {31'b0, m_tvalid}, 32'd0);
        check_eq("midrst_err", {31'b0, err}, 32'd0);
        resetn = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        model_line(8, 1'b1, vecs[2].top, vecs[2].mid, vecs[2].bot);
        send_line(8, 1'b1, vecs[2].top, vecs[2].mid, vecs[2].bot, 1'b1, 1'b0);
        drain();
        check_eq("post_rst_err", {31'b0, err}, 32'd0);

        // Frame restart mid-line: partial line flushed, then new frame from column 0.
        for (int i = 0; i < 8; i++) begin
            rt[i] = 8'($urandom); rm[i] = 8'($urandom); rb[i] = 8'($urandom);
        end
        model_line(3, 1'b0, rt, rm, rb);
        model_line(8, 1'b1, vecs[1].top, vecs[1].mid, vecs[1].bot);
        send_line(3, 1'b0, rt, rm, rb, 1'b0, 1'b0);
        send_line(8, 1'b1, vecs[1].top, vecs[1].mid, vecs[1].bot, 1'b1, 1'b0);
        drain();
        check_eq("restart_err", {31'b0, err}, 32'd1);

        // Randomized lines, random backpressure and partial-valid glitches.
        rmode = 2;
        for (int n = 0; n < 12; n++) begin
            int unsigned len;
            len = (n % 3 == 0) ? 32'($urandom_range(1, 8)) : 32'(W);
            for (int i = 0; i < 8; i++) begin
                rt[i] = 8'($urandom); rm[i] = 8'($urandom); rb[i] = 8'($urandom);
            end
            model_line(len, n == 0, rt, rm, rb);
            send_line(len, n == 0, rt, rm, rb, 1'b1, 1'b1);
        end
        drain();

        // Same directed table with ready toggling every cycle.
        rmode = 1;
        run_table(1'b1);

        rmode = 0;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
